reg_rx_requests_ctrl: RTL and testbench
=======================================

REG_RX_REQUESTS_CTRL -- requirements
Module: reg_rx_requests_ctrl

Interface
REQ-001 Parameter RX_DATA_WIDTH, default 8, width of one received byte.
REQ-002 Parameter REG_ADDR_WIDTH, default 8, register address width.
REQ-003 Parameter REG_DATA_WIDTH, default 16, register data width.
REQ-004 Parameter ADDR_REQUESTS, default 0, address of the requests register.
REQ-005 Parameter DEFAULT_REQUESTS, default 0, reset value of the requests register.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 rx_data  in  RX_DATA_WIDTH  received byte.
REQ-009 rx_rdy  in  1  rx_data valid.
REQ-010 rx_ack  out  1  byte consumed.
REQ-011 register_addr  out  REG_ADDR_WIDTH  assembled address.
REQ-012 register_data  out  REG_DATA_WIDTH  assembled data.
REQ-013 register_rdy  out  1  one-cycle strobe, addr/data valid.
REQ-014 start_o, stop_o, rqst_ch1, rqst_ch2, rqst_trigger_status_o, reset_o  out  1 each  request strobes.

Function
REQ-015 Frame = NA = ceil(REG_ADDR_WIDTH/RX_DATA_WIDTH) address bytes, then ND = ceil(REG_DATA_WIDTH/RX_DATA_WIDTH) data bytes; default frame is 3 bytes.
REQ-016 Within each field, bytes arrive most-significant first; excess bits of the last byte are discarded.
REQ-017 Byte accepted on any rising edge with rx_rdy=1; rx_ack is registered, high exactly the cycle after acceptance, one cycle per byte.
REQ-018 Back-to-back bytes (rx_rdy held high) are accepted every cycle; no byte is dropped.
REQ-019 Assembler FSM states: ADDR (collecting address bytes), DATA (collecting data bytes); ADDR->DATA after NA bytes, DATA->ADDR after ND bytes.
REQ-020 register_rdy pulses high for one cycle, the cycle after the last data byte is accepted; register_addr/register_data update that same cycle and hold until the next frame completes.
REQ-021 Requests register: on register_rdy=1 and register_addr==ADDR_REQUESTS, loads register_data, visible the next cycle; on any other cycle it clears to 0, so each output is a one-cycle strobe.
REQ-022 Bit map: bit0 start_o, bit1 stop_o, bit2 rqst_ch1, bit3 rqst_ch2, bit4 rqst_trigger_status_o, bit5 reset_o; other bits ignored.
REQ-023 Writes to other addresses leave all strobes low.
REQ-024 Strobe latency: 2 cycles after acceptance of the final frame byte.

Reset
REQ-025 While rst=0: FSM in ADDR with byte count 0; rx_ack=0, register_rdy=0, register_addr=0, register_data=0.
REQ-026 While rst=0 the requests register holds DEFAULT_REQUESTS; after release it clears to 0 on the first clock edge unless loaded.
REQ-027 Reset asserted mid-frame discards the partial frame; the next accepted byte is an address byte.

Structure
REQ-028 Shared package holds default widths and request bit indices (START=0, STOP=1, RQST_CH1=2, RQST_CH2=3, RQST_TRIG=4, RESET=5).
REQ-029 One sub-module is natural: rx_frame_assembler (bytes -> addr/data/rdy); request decode stays in the top level.

Verification
REQ-030 Bytes 0x00,0x12,0x34 (ADDR_REQUESTS=0) -> register_addr=0x00, register_data=0x1234, single register_rdy pulse; three rx_ack pulses.
REQ-031 Frame 0x00,0x00,0x01 -> start_o high for exactly one cycle, 2 cycles after the last byte; all other strobes low.
REQ-032 Frame 0x00,0x00,0x3F -> all six strobes pulse together for one cycle.
REQ-033 Frame 0x05,0x00,0x01 -> register_rdy pulses, all strobes remain low.
REQ-034 rst low after 2 of 3 bytes, then frame 0x00,0x00,0x02 -> stop_o pulses only; no spurious register_rdy.
REQ-035 DEFAULT_REQUESTS=0x01, hold rst low -> start_o=1; release -> start_o=0 after the first clock edge.

Source files
------------

// File: rtl/reg_rx_requests_ctrl_pkg.sv
// Shared widths, request bit map and assembler state type
// for the byte-stream register request controller.
package reg_rx_requests_ctrl_pkg;

    localparam int RX_DATA_W  = 8;
    localparam int REG_ADDR_W = 8;
    localparam int REG_DATA_W = 16;

    localparam int REQ_START     = 0;
    localparam int REQ_STOP      = 1;
    localparam int REQ_RQST_CH1  = 2;
    localparam int REQ_RQST_CH2  = 3;
    localparam int REQ_RQST_TRIG = 4;
    localparam int REQ_RESET     = 5;
    localparam int NUM_REQ       = 6;

    typedef enum logic {
        ST_ADDR,
        ST_DATA
    } asm_state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/reg_rx_requests_ctrl_rx_frame_assembler.sv
// Collects address then data bytes (MSB first) into one
// register write and strobes register_rdy when complete.
module rx_frame_assembler
    import reg_rx_requests_ctrl_pkg::*;
#(
    parameter int RX_DATA_WIDTH  = RX_DATA_W,
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int REG_DATA_WIDTH = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RX_DATA_WIDTH-1:0]  rx_data,
    input  logic                      rx_rdy,
    output logic                      rx_ack,
    output logic [REG_ADDR_WIDTH-1:0] register_addr,
    output logic [REG_DATA_WIDTH-1:0] register_data,
    output logic                      register_rdy
);

    localparam int NA   = ceil_div(REG_ADDR_WIDTH, RX_DATA_WIDTH);
    localparam int ND   = ceil_div(REG_DATA_WIDTH, RX_DATA_WIDTH);
    localparam int AB   = NA * RX_DATA_WIDTH;
    localparam int DB   = ND * RX_DATA_WIDTH;
    localparam int NMAX = (NA > ND) ? NA : ND;
    localparam int CW   = $clog2(NMAX + 1);

    asm_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [NA-1:0][RX_DATA_WIDTH-1:0] abuf_q, abuf_d;
    logic [ND-1:0][RX_DATA_WIDTH-1:0] dbuf_q, dbuf_d;
    logic [AB-1:0] aflat;
    logic [DB-1:0] dflat;

    logic                      ack_q;
    logic [REG_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      rrdy_q, rrdy_d;

    // First byte of a field lands in the top slot (MSB first)
    always_comb begin
        abuf_d = abuf_q;
        dbuf_d = dbuf_q;
        if (rx_rdy) begin
            if (state_q == ST_ADDR) begin
                for (int i = 0; i < NA; i++) begin
                    if (int'(cnt_q) == NA - 1 - i) begin
                        abuf_d[i] = rx_data;
                    end
                end
            end else begin
                for (int i = 0; i < ND; i++) begin
                    if (int'(cnt_q) == ND - 1 - i) begin
                        dbuf_d[i] = rx_data;
                    end
                end
            end
        end
    end

    assign aflat = abuf_q;
    assign dflat = dbuf_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        rrdy_d  = 1'b0;
        if (rx_rdy) begin
            unique case (state_q)
                ST_ADDR: begin
                    if (cnt_q == CW'(NA - 1)) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CW'(ND - 1)) begin
                        state_d = ST_ADDR;
                        cnt_d   = '0;
                        // Excess low bits of a field's last byte drop out
                        raddr_d = aflat[AB-1 -: REG_ADDR_WIDTH];
                        rdata_d = dflat[DB-1 -: REG_DATA_WIDTH];
                        rrdy_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ADDR;
            cnt_q   <= '0;
            abuf_q  <= '0;
            dbuf_q  <= '0;
            ack_q   <= 1'b0;
            raddr_q <= '0;
            rdata_q <= '0;
            rrdy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abuf_q  <= abuf_d;
            dbuf_q  <= dbuf_d;
            ack_q   <= rx_rdy;
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
            rrdy_q  <= rrdy_d;
        end
    end

    assign rx_ack        = ack_q;
    assign register_addr = raddr_q;
    assign register_data = rdata_q;
    assign register_rdy  = rrdy_q;

endmodule

// File: rtl/reg_rx_requests_ctrl.sv
// Turns writes to the requests register address into
// one-cycle request strobes.
module reg_rx_requests_ctrl
    import reg_rx_requests_ctrl_pkg::*;
#(
    parameter int RX_DATA_WIDTH  = RX_DATA_W,
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int REG_DATA_WIDTH = REG_DATA_W,
    parameter logic [REG_ADDR_WIDTH-1:0] ADDR_REQUESTS    = '0,
    parameter logic [REG_DATA_WIDTH-1:0] DEFAULT_REQUESTS = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [RX_DATA_WIDTH-1:0]  rx_data,
    input  logic                      rx_rdy,
    output logic                      rx_ack,
    output logic [REG_ADDR_WIDTH-1:0] register_addr,
    output logic [REG_DATA_WIDTH-1:0] register_data,
    output logic                      register_rdy,
    output logic                      start_o,
    output logic                      stop_o,
    output logic                      rqst_ch1,
    output logic                      rqst_ch2,
    output logic                      rqst_trigger_status_o,
    output logic                      reset_o
);

    logic [NUM_REQ-1:0] req_q, req_d;

    rx_frame_assembler #(
        .RX_DATA_WIDTH  (RX_DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .REG_DATA_WIDTH (REG_DATA_WIDTH)
    ) u_asm (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_rdy        (rx_rdy),
        .rx_ack        (rx_ack),
        .register_addr (register_addr),
        .register_data (register_data),
        .register_rdy  (register_rdy)
    );

    // Self-clearing: anything but a matching write zeroes it
    always_comb begin
        req_d = '0;
        if (register_rdy && register_addr == ADDR_REQUESTS) begin
            req_d = register_data[NUM_REQ-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= DEFAULT_REQUESTS[NUM_REQ-1:0];
        end else begin
            req_q <= req_d;
        end
    end

    assign start_o               = req_q[REQ_START];
    assign stop_o                = req_q[REQ_STOP];
    assign rqst_ch1              = req_q[REQ_RQST_CH1];
    assign rqst_ch2              = req_q[REQ_RQST_CH2];
    assign rqst_trigger_status_o = req_q[REQ_RQST_TRIG];
    assign reset_o               = req_q[REQ_RESET];

endmodule

// File: tb/tb_reg_rx_requests_ctrl.sv
// Frame-level model of the request controller, checked every
// cycle, plus directed frames with hand-computed results.
module tb_reg_rx_requests_ctrl;

    localparam logic [7:0]  AREQ = 8'h00;
    localparam logic [15:0] DEFR = 16'h0001;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        rx_ack;
    logic [7:0]  register_addr;
    logic [15:0] register_data;
    logic        register_rdy;
    logic        start_o, stop_o, rqst_ch1, rqst_ch2;
    logic        rqst_trigger_status_o, reset_o;

    int n_vec = 0;
    int n_err = 0;

    reg_rx_requests_ctrl #(
        .RX_DATA_WIDTH    (8),
        .REG_ADDR_WIDTH   (8),
        .REG_DATA_WIDTH   (16),
        .ADDR_REQUESTS    (AREQ),
        .DEFAULT_REQUESTS (DEFR)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rx_data               (rx_data),
        .rx_rdy                (rx_rdy),
        .rx_ack                (rx_ack),
        .register_addr         (register_addr),
        .register_data         (register_data),
        .register_rdy          (register_rdy),
        .start_o               (start_o),
        .stop_o                (stop_o),
        .rqst_ch1              (rqst_ch1),
        .rqst_ch2              (rqst_ch2),
        .rqst_trigger_status_o (rqst_trigger_status_o),
        .reset_o               (reset_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [5:0] strobes = {reset_o, rqst_trigger_status_o, rqst_ch2,
                          rqst_ch1, stop_o, start_o};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: a frame is three bytes; addr = byte0, data = byte1:byte2.
    logic [1:0]  fcnt;
    logic [7:0]  fb0, fb1;
    logic        exp_ack, exp_rdy;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
    logic [5:0]  exp_req;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt     <= 2'd0;
            fb0      <= 8'h00;
            fb1      <= 8'h00;
            exp_ack  <= 1'b0;
            exp_rdy  <= 1'b0;
            exp_addr <= 8'h00;
            exp_data <= 16'h0000;
            exp_req  <= DEFR[5:0];
        end else begin
            exp_req <= (exp_rdy && exp_addr == AREQ) ? exp_data[5:0] : 6'h00;
            exp_ack <= rx_rdy;
            exp_rdy <= 1'b0;
            if (rx_rdy) begin
                case (fcnt)
                    2'd0: begin fb0 <= rx_data; fcnt <= 2'd1; end
                    2'd1: begin fb1 <= rx_data; fcnt <= 2'd2; end
                    default: begin
                        exp_addr <= fb0;
                        exp_data <= {fb1, rx_data};
                        exp_rdy  <= 1'b1;
                        fcnt     <= 2'd0;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("rx_ack", 32'(rx_ack), 32'(exp_ack));
        chk("register_rdy", 32'(register_rdy), 32'(exp_rdy));
        chk("register_addr", 32'(register_addr), 32'(exp_addr));
        chk("register_data", 32'(register_data), 32'(exp_data));
        chk("strobes", 32'(strobes), 32'(exp_req));
    end

    task automatic send_byte(input logic [7:0] b);
        rx_rdy  = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d1,
                              input logic [7:0] d0);
        send_byte(a);
        send_byte(d1);
        send_byte(d0);
        rx_rdy = 1'b0;
    endtask

    // Checks the rdy cycle and the strobe cycle after a frame
    task automatic frame_lit(input string nm, input logic [7:0] a,
                             input logic [15:0] d, input logic [5:0] s);
        @(negedge clk);
        chk({nm, "_rdy"}, 32'(register_rdy), 32'd1);
        chk({nm, "_addr"}, 32'(register_addr), 32'(a));
        chk({nm, "_data"}, 32'(register_data), 32'(d));
        chk({nm, "_early"}, 32'(strobes), 32'd0);
        @(negedge clk);
        chk({nm, "_rdy_off"}, 32'(register_rdy), 32'd0);
        chk({nm, "_strobe"}, 32'(strobes), 32'(s));
        @(negedge clk);
        chk({nm, "_strobe_off"}, 32'(strobes), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_start", 32'(start_o), 32'd1);
        chk("rst_addr", 32'(register_addr), 32'd0);
        chk("rst_ack", 32'(rx_ack), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rel_start_hold", 32'(start_o), 32'd1);
        @(negedge clk);
        chk("rel_start_clr", 32'(start_o), 32'd0);
        @(posedge clk);
        #1;

        send_frame(8'h00, 8'h12, 8'h34);
        frame_lit("f1234", 8'h00, 16'h1234, 6'h34);
        send_frame(8'h00, 8'h00, 8'h01);
        frame_lit("fstart", 8'h00, 16'h0001, 6'h01);
        send_frame(8'h00, 8'h00, 8'h3F);
        frame_lit("fall", 8'h00, 16'h003F, 6'h3F);
        send_frame(8'h05, 8'h00, 8'h01);
        frame_lit("fother", 8'h05, 16'h0001, 6'h00);

        send_byte(8'h00);
        send_byte(8'h00);
        rx_rdy = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", 32'(register_rdy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h00, 8'h00, 8'h02);
        frame_lit("fstop", 8'h00, 16'h0002, 6'h02);

        repeat (3000) begin
            rx_rdy  = ($urandom_range(0, 3) != 0);
            rx_data = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            rst     = ($urandom_range(0, 299) != 0);
            @(posedge clk);
            #1;
        end
        rst    = 1'b1;
        rx_rdy = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
